// File: rtl/session_controller.sv
// Session controller: sequences a user through login, game, scoreboard and lockout.
// Moore FSM. Every output except the debug state is registered from the current state,
// so outputs follow a state change by one cycle.
module session_controller #(
  parameter int unsigned ATTEMPT_MAX    = 3,
  parameter int unsigned LOCK_CYCLES    = 8,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] buttons,
  input  logic       access_grant,
  input  logic       access_fail,
  input  logic       game_over,
  output logic [2:0] buttons_select,
  output logic       switches_select,
  output logic [3:0] lcd_control,
  output logic [1:0] led_control,
  output logic [1:0] game_score_select,
  output logic       access_control_reset,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StLogin   = 3'd1,
    StGame    = 3'd2,
    StScore   = 3'd3,
    StLockout = 3'd4
  } state_e;

  localparam logic [23:0] LockLast    = 24'(LOCK_CYCLES - 1);
  localparam logic [23:0] TimeoutLast = 24'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]  AttemptMax  = 3'(ATTEMPT_MAX);

  state_e      state_q, state_d;
  logic [2:0]  fail_cnt_q, fail_cnt_d;
  logic [23:0] inact_q, inact_d;
  logic [23:0] lock_q, lock_d;
  // Set for one cycle after a rejected password that does not lock out; it drives the
  // single-cycle access control reset pulse.
  logic        retry_q, retry_d;
  logic [2:0]  fail_inc;

  logic [2:0]  bsel_q, bsel_d;
  logic        ssel_q, ssel_d;
  logic [3:0]  lcd_q, lcd_d;
  logic [1:0]  led_q, led_d;
  logic [1:0]  gss_q, gss_d;
  logic        acr_q, acr_d;

  assign fail_inc = (fail_cnt_q == 3'd7) ? 3'd7 : 3'(fail_cnt_q + 3'd1);

  // Next-state, attempt counter and the two 24-bit timers.
  always_comb begin
    state_d    = state_q;
    fail_cnt_d = fail_cnt_q;
    inact_d    = inact_q;
    lock_d     = lock_q;
    retry_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (buttons[0]) begin
          state_d = StLogin;
          inact_d = '0;
        end
      end
      StLogin: begin
        if (access_grant) begin
          state_d    = StGame;
          fail_cnt_d = '0;
        end else if (access_fail) begin
          fail_cnt_d = fail_inc;
          inact_d    = '0;
          if (fail_inc == AttemptMax) begin
            state_d = StLockout;
            lock_d  = '0;
          end else begin
            retry_d = 1'b1;
          end
        end else if (|buttons) begin
          inact_d = '0;
        end else if (inact_q == TimeoutLast) begin
          // fail_cnt is kept so a timeout cannot reset the attempt budget
          state_d = StIdle;
        end else begin
          inact_d = inact_q + 24'd1;
        end
      end
      StGame: begin
        if (game_over) begin
          state_d = StScore;
        end
      end
      StScore: begin
        if (buttons[2]) begin
          state_d    = StIdle;
          fail_cnt_d = '0;
        end else if (buttons[0]) begin
          state_d = StGame;
        end
      end
      StLockout: begin
        if (lock_q == LockLast) begin
          state_d    = StIdle;
          fail_cnt_d = '0;
        end else begin
          lock_d = lock_q + 24'd1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Output decode from the current state; registered below.
  always_comb begin
    bsel_d = 3'd0;
    ssel_d = 1'b0;
    lcd_d  = 4'd0;
    led_d  = 2'b00;
    gss_d  = 2'd0;
    acr_d  = 1'b0;
    unique case (state_q)
      StLogin: begin
        bsel_d = 3'd1;
        ssel_d = 1'b1;
        lcd_d  = (fail_cnt_q != 3'd0) ? 4'd2 : 4'd1;
        acr_d  = ~retry_q;
      end
      StGame: begin
        bsel_d = 3'd2;
        lcd_d  = 4'd3;
        led_d  = 2'b10;
        gss_d  = 2'd1;
        acr_d  = 1'b1;
      end
      StScore: begin
        bsel_d = 3'd3;
        lcd_d  = 4'd4;
        led_d  = 2'b10;
        gss_d  = 2'd2;
        acr_d  = 1'b1;
      end
      StLockout: begin
        lcd_d = 4'd5;
        led_d = 2'b01;
      end
      default: begin
        bsel_d = 3'd0;
      end
    endcase
  end

  // State, counters and timers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      fail_cnt_q <= '0;
      inact_q    <= '0;
      lock_q     <= '0;
      retry_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fail_cnt_q <= fail_cnt_d;
      inact_q    <= inact_d;
      lock_q     <= lock_d;
      retry_q    <= retry_d;
    end
  end

  // Registered outputs; reset values equal the IDLE decode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bsel_q <= 3'd0;
      ssel_q <= 1'b0;
      lcd_q  <= 4'd0;
      led_q  <= 2'b00;
      gss_q  <= 2'd0;
      acr_q  <= 1'b0;
    end else begin
      bsel_q <= bsel_d;
      ssel_q <= ssel_d;
      lcd_q  <= lcd_d;
      led_q  <= led_d;
      gss_q  <= gss_d;
      acr_q  <= acr_d;
    end
  end

  assign buttons_select       = bsel_q;
  assign switches_select      = ssel_q;
  assign lcd_control          = lcd_q;
  assign led_control          = led_q;
  assign game_score_select    = gss_q;
  assign access_control_reset = acr_q;
  assign state                = state_q;

endmodule

// File: doc/session_controller.md
SESSION_CONTROLLER -- requirements
Module: session_controller

Interface
REQ-001 SHALL have parameter ATTEMPT_MAX, default 3, meaning failed logins before lockout (range 1..7).
REQ-002 SHALL have parameter LOCK_CYCLES, default 8, meaning lockout duration in clk cycles (range 1..2^24).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning LOGIN inactivity limit in clk cycles (range 1..2^24).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port buttons, input, 3 bits: shaped one-cycle button pulses, taken before the button decoder.
REQ-007 SHALL have port access_grant, input, 1 bit: level, high while access control grants a user.
REQ-008 SHALL have port access_fail, input, 1 bit: one-cycle pulse per rejected password.
REQ-009 SHALL have port game_over, input, 1 bit: one-cycle pulse when the game ends.
REQ-010 SHALL have port buttons_select, output, 3 bits: button decoder route (0 ctrl, 1 access, 2 game, 3 scoreboard).
REQ-011 SHALL have port switches_select, output, 1 bit: 1 routes toggle switches to the datapath.
REQ-012 SHALL have port lcd_control, output, 4 bits: LCD message code.
REQ-013 SHALL have port led_control, output, 2 bits: [0] red, [1] green.
REQ-014 SHALL have port game_score_select, output, 2 bits: score mux select (0 none, 1 game, 2 scoreboard).
REQ-015 SHALL have port access_control_reset, output, 1 bit: active-low reset to access control.
REQ-016 SHALL have port state, output, 3 bits: current state encoding, for debug.

Function
REQ-017 SHALL be a Moore FSM with all outputs registered and decoded from state only; outputs SHALL change in the cycle after the state register updates.
REQ-018 SHALL encode states IDLE=0, LOGIN=1, GAME=2, SCORE=3, LOCKOUT=4; codes 5..7 SHALL go to IDLE on the next clk.
REQ-019 SHALL drive the following outputs per state (buttons_select/switches_select/lcd_control/led_control/game_score_select/access_control_reset): IDLE 0/0/0/00/0/0; LOGIN 1/1/1/00/0/1; GAME 2/0/3/10/1/1; SCORE 3/0/4/10/2/1; LOCKOUT 0/0/5/01/0/0.
REQ-020 In LOGIN, lcd_control SHALL read 2 ("retry") instead of 1 while fail_cnt is nonzero.
REQ-021 IDLE SHALL go to LOGIN on buttons[0]; other buttons SHALL be ignored.
REQ-022 LOGIN SHALL go to GAME when access_grant is high and SHALL clear fail_cnt on that transition.
REQ-023 On an access_fail pulse in LOGIN, fail_cnt SHALL increment by 1 (3-bit, saturating).
REQ-024 When the incremented fail_cnt equals ATTEMPT_MAX, LOGIN SHALL go to LOCKOUT.
REQ-025 Otherwise a failed attempt SHALL keep the FSM in LOGIN and pulse access_control_reset low for exactly one cycle.
REQ-026 If access_grant and access_fail are high in the same cycle, access_grant SHALL win.
REQ-027 The LOGIN inactivity counter (24-bit) SHALL clear on LOGIN entry and on any buttons or access_fail pulse.
REQ-028 The LOGIN inactivity counter SHALL otherwise increment, and LOGIN SHALL go to IDLE when it reaches TIMEOUT_CYCLES-1.
REQ-029 A LOGIN timeout SHALL preserve fail_cnt, so that a timeout cannot bypass lockout.
REQ-030 GAME SHALL go to SCORE on game_over; buttons SHALL be ignored by the controller in GAME.
REQ-031 SCORE SHALL go to IDLE on buttons[2] (logout) and clear fail_cnt; SCORE SHALL go to GAME on buttons[0].
REQ-032 If buttons[2] and buttons[0] arrive in the same cycle in SCORE, buttons[2] SHALL win.
REQ-033 The lockout counter (24-bit) SHALL clear on LOCKOUT entry and increment each cycle; all inputs SHALL be ignored in LOCKOUT.
REQ-034 LOCKOUT SHALL go to IDLE when the lockout counter reaches LOCK_CYCLES-1, clearing fail_cnt; LOCKOUT SHALL therefore last exactly LOCK_CYCLES cycles.
REQ-035 Pulses arriving in a state where they are not listed SHALL have no effect and SHALL not be queued.

Reset
REQ-036 While rst=0, state, fail_cnt and both counters SHALL be 0 and all outputs SHALL take their IDLE values, including access_control_reset=0.
REQ-037 Assertion of rst mid-operation (any state) SHALL force IDLE asynchronously; release SHALL take effect on the first clk edge after rst rises.

Verification
REQ-038 Reset, then buttons[0] pulse, then access_grant=1 -> state 0->1->2; in GAME, led_control=10, buttons_select=2, game_score_select=1.
REQ-039 In LOGIN, 3 access_fail pulses 2 cycles apart -> after pulses 1 and 2, one-cycle access_control_reset=0 and lcd_control=2; after pulse 3, state=4, led_control=01.
REQ-040 In LOCKOUT with LOCK_CYCLES=8 -> exactly 8 cycles in state 4 with buttons[0] pulses ignored, then state=0 and fail_cnt=0.
REQ-041 In LOGIN, 1 fail then 16 idle cycles -> state=0; a second login followed by 2 fails -> LOCKOUT (fail count preserved).
REQ-042 GAME, game_over -> SCORE (buttons_select=3); then simultaneous buttons[2] and buttons[0] -> IDLE.
REQ-043 rst asserted low in SCORE between clock edges -> outputs immediately take IDLE values.
